// File: rtl/perceptron_ser_if.sv
// Handshake and result bundle between the image source (master) and perceptron_ser (slave).
interface perceptron_ser_if #(
  parameter int N_IN = 25,
  parameter int WW   = 8
);
  localparam int SW = WW + $clog2(N_IN + 1) + 1;

  logic                 start;
  logic [N_IN-1:0]      in;
  logic                 train;
  logic                 label;
  logic                 ready;
  logic                 done;
  logic                 out_class;
  logic signed [SW-1:0] score;
  logic                 updated;

  modport master (
    output start, in, train, label,
    input  ready, done, out_class, score, updated
  );

  modport slave (
    input  start, in, train, label,
    output ready, done, out_class, score, updated
  );
endinterface

// File: rtl/perceptron_ser.sv
// Serial perceptron: one pixel per cycle MAC, then optional on-line perceptron-rule update.
// Define PERCEPTRON_SAT_EN to make weight/bias updates saturate instead of wrapping.
module perceptron_ser #(
  parameter int N_IN = 25,
  parameter int WW   = 8,
  parameter int LR   = 1
) (
  input logic             clk,
  input logic             rst,
  perceptron_ser_if.slave bus
);
  localparam int SW = WW + $clog2(N_IN + 1) + 1;
  localparam int IW = $clog2(N_IN + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(N_IN - 1);
  localparam logic [IW-1:0] BIAS_IDX = IW'(N_IN);
  localparam logic signed [WW+1:0] LR_EXT = (WW + 2)'(LR);

  typedef enum logic [2:0] {IDLE, ACC, CMP, UPD, DONE} state_t;

  state_t               state;
  logic [N_IN-1:0]      in_q;
  logic                 train_q;
  logic                 label_q;
  logic [IW-1:0]        idx;
  logic signed [SW-1:0] acc;
  logic signed [WW-1:0] w [N_IN];
  logic signed [WW-1:0] bias;
  logic                 cls;

  // Two guard bits hold v +/- LR exactly (LR may equal 2^(WW-1)) before wrap or clamp.
  function automatic logic signed [WW-1:0] step(input logic signed [WW-1:0] v, input logic up);
    logic signed [WW+1:0] t;
`ifdef PERCEPTRON_SAT_EN
    logic signed [WW+1:0] max_ext;
    logic signed [WW+1:0] min_ext;
    max_ext = {3'b000, {(WW-1){1'b1}}};
    min_ext = {3'b111, {(WW-1){1'b0}}};
`endif
    t = (WW + 2)'(v) + (up ? LR_EXT : -LR_EXT);
`ifdef PERCEPTRON_SAT_EN
    if (t > max_ext)      t = max_ext;
    else if (t < min_ext) t = min_ext;
`endif
    return WW'(t);
  endfunction

  always_comb begin
    cls = (acc > 0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      bus.ready     <= 1'b1;
      bus.done      <= 1'b0;
      bus.out_class <= 1'b0;
      bus.score     <= '0;
      bus.updated   <= 1'b0;
      in_q          <= '0;
      train_q       <= 1'b0;
      label_q       <= 1'b0;
      idx           <= '0;
      acc           <= '0;
      bias          <= '0;
      for (int unsigned i = 0; i < N_IN; i++) w[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            in_q      <= bus.in;
            train_q   <= bus.train;
            label_q   <= bus.label;
            acc       <= SW'(bias);
            idx       <= '0;
            bus.ready <= 1'b0;
            state     <= ACC;
          end
        end
        ACC: begin
          if (in_q[idx]) acc <= acc + SW'(w[idx]);
          idx <= idx + 1'b1;
          if (idx == LAST_IDX) state <= CMP;
        end
        CMP: begin
          bus.score     <= acc;
          bus.out_class <= cls;
          if (train_q && (cls != label_q)) begin
            idx   <= '0;
            state <= UPD;
          end else begin
            bus.updated <= 1'b0;
            bus.done    <= 1'b1;
            state       <= DONE;
          end
        end
        UPD: begin
          // idx == N_IN is the extra cycle that steps the bias.
          if (idx == BIAS_IDX) begin
            bias        <= step(bias, label_q);
            bus.updated <= 1'b1;
            bus.done    <= 1'b1;
            state       <= DONE;
          end else begin
            if (in_q[idx]) w[idx] <= step(w[idx], label_q);
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          bus.done  <= 1'b0;
          bus.ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/perceptron_ser.md
Name: perceptron_ser

Overview:
- Parametrised successor to the fixed 25-pixel cross/circle perceptron.
- Binary linear classifier over an N_IN-pixel binary image using signed weights plus a bias, held in on-chip registers.
- Serial MAC evaluates one pixel per cycle, then an optional on-line training pass applies the perceptron rule on misclassification.
- Sits between the image source, which drives the start/ready handshake, and the downstream decision logic.

Parameters:
- N_IN, 25, number of binary input pixels; bit i is pixel i, and bit N_IN-1 is the top-left pixel.
- WW, 8, signed weight and bias width in two's complement.
- LR, 1, learning-rate magnitude added to or subtracted from weights on update; legal range 1..2^(WW-1).
- SW, WW+$clog2(N_IN+1)+1, signed score width (derived; not to be overridden).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; accepted only when start && ready
- in  in  N_IN  pixel vector, sampled on the accepting edge
- train  in  1  training request, sampled with in
- label  in  1  target class (1 = cross, 0 = circle), sampled with in
- ready  out  1  high only in IDLE
- done  out  1  one-cycle completion pulse
- out_class  out  1  result class, valid from done until the next done
- score  out  SW  signed bias+sum(w_i*in_i), held with out_class
- updated  out  1  1 if the finishing operation changed the weights

Behaviour:
- Reset (asynchronous, active-high) forces:
  - state IDLE, ready=1, done=0, out_class=0, score=0, updated=0;
  - all N_IN weights and the bias to 0, index counter to 0.
- Reset mid-operation: the operation is abandoned and the weights/bias return to 0.
- State machine:
  - IDLE: on start&&ready, latch in/train/label into shadow registers, set acc=bias, idx=0, go to ACC. start while not ready is ignored; there is no queue.
  - ACC (N_IN cycles): acc += in_q[idx] ? w[idx] : 0; idx increments; after idx=N_IN-1, go to CMP. in, train and label may change freely during ACC.
  - CMP (1 cycle): class = (acc > 0), signed strict compare, so score 0 gives class 0. Register score=acc and out_class=class. If train_q && class!=label_q, set idx=0 and go to UPD; otherwise go to DONE with updated=0.
  - UPD (N_IN+1 cycles): for idx<N_IN, if in_q[idx] then w[idx] += (label_q ? +LR : -LR); the final cycle applies the same step to the bias unconditionally. Then go to DONE with updated=1.
  - DONE (1 cycle): done=1, ready=0; next state IDLE.
- Latency from the accepting edge E0 until done is high:
  - inference, or training with a correct prediction: done starts at E0+N_IN+2;
  - training with an update: done starts at E0+2*N_IN+3.
- Back-to-back: start may be held high; the next start is accepted in the IDLE cycle after DONE.
- score and out_class report the pre-update evaluation; the update affects only later operations.
- The accumulator is SW bits wide and cannot overflow for any weight values.

Optional Feature:
- Macro: PERCEPTRON_SAT_EN.
- Defined: each weight and bias update saturates to [-2^(WW-1), 2^(WW-1)-1].
- Undefined: updates wrap modulo 2^WW in two's complement.
- All other behaviour is identical with or without the macro.

Test Plan:
- Pixel images used below: cross = 25'h1151151 (9 pixels set); circle = 25'h0454544 (8 pixels set, 4 shared with cross).
- Reset, then infer cross with train=0 -> done at E0+27, score=0, out_class=0, updated=0, ready low for 27 cycles.
- Train cross with label=1 -> done at E0+53, score=0, updated=1. A following cross inference -> score=10, out_class=1; a circle inference -> score=5, out_class=1.
- Continuing from there, train circle with label=0 -> updated=1, bias back to 0. Then cross -> score=5, out_class=1; circle -> score=-4, out_class=0. Retraining either image with its correct label -> updated=0, done at E0+27.
- Hold start=1 continuously across three cross inferences -> exactly three done pulses, 28 cycles apart, with start ignored while ready=0.
- Assert rst during UPD of a training operation -> done never pulses for that operation; the next cross inference gives score=0, out_class=0.
- With WW=4, LR=8, train cross label=1 -> the 9 cross weights and the bias read 7 with PERCEPTRON_SAT_EN, or -8 without it. A following cross inference -> score=70 with the macro, -80 without it.
